phys_reg_free_list: RTL and testbench



---
 rtl/phys_reg_free_list.sv | 107 ++++++++++
 tb/tb_phys_reg_free_list.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - circular free list of physical registers with single-branch checkpoint/recover
//
// Purpose:
//   Holds the physical register numbers that rename may hand out. Decode pops
//   the head on alloc_grant; writeback pushes retired mappings at the tail.
//   A single snapshot of the head pointer lets a mispredict squash younger
//   allocations by rewinding the head.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   alloc_req    rename wants a destination register this cycle
//   alloc_valid  list non-empty
//   alloc_phys   register at head, meaningful when alloc_valid
//   alloc_grant  head pops on this edge (alloc_req & alloc_valid & ~recover)
//   free_valid   writeback returns a register this cycle
//   free_phys    register being returned
//   checkpoint   snapshot the post-pop head pointer
//   recover      rewind head to the snapshot
//   free_count   current occupancy
//   err_overflow sticky: return dropped because the list was full
//   err_zero     sticky: physical register 0 was returned

module phys_reg_free_list #(
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHYS = 64,
  parameter int PHYS_W   = $clog2(NUM_PHYS),
  localparam int DEPTH   = NUM_PHYS - NUM_ARCH,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [PHYS_W-1:0] alloc_phys,
  output logic              alloc_grant,
  input  logic              free_valid,
  input  logic [PHYS_W-1:0] free_phys,
  input  logic              checkpoint,
  input  logic              recover,
  output logic [CNT_W-1:0]  free_count,
  output logic              err_overflow,
  output logic              err_zero
);

  localparam int IDX_W = CNT_W - 1;

  logic [PHYS_W-1:0] entry [DEPTH];
  logic [CNT_W-1:0]  head;
  logic [CNT_W-1:0]  tail;
  logic [CNT_W-1:0]  snap;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  head_nxt;
  logic              free_is_zero;
  logic              free_accept;
  logic              free_drop;

  // Pointers carry an extra wrap bit so full (count == DEPTH) and empty
  // (count == 0) are distinguishable; the subtraction wraps naturally.
  assign count       = tail - head;
  assign free_count  = count;
  assign alloc_valid = (count != '0);
  assign alloc_phys  = entry[head[IDX_W-1:0]];
  assign alloc_grant = alloc_req & alloc_valid & ~recover;

  assign free_is_zero = free_valid & (free_phys == '0);
  // A same-cycle pop frees a slot, so a full list still accepts the return.
  assign free_accept  = free_valid & ~free_is_zero &
                        ((count < CNT_W'(DEPTH)) | alloc_grant);
  assign free_drop    = free_valid & ~free_is_zero & ~free_accept;

  // Recover wins over a pop (the grant is suppressed anyway); the snapshot
  // always captures this value so a checkpoint keeps the branch's own pop
  // and a checkpoint during recover captures the restored head.
  assign head_nxt = recover ? snap : head + CNT_W'(alloc_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= PHYS_W'(NUM_ARCH + i);
      end
      head         <= '0;
      tail         <= CNT_W'(DEPTH);
      snap         <= '0;
      err_overflow <= 1'b0;
      err_zero     <= 1'b0;
    end else begin
      head <= head_nxt;
      if (checkpoint) begin
        snap <= head_nxt;
      end
      // Squashed allocations between snap and head are never overwritten
      // because tail only advances into slots counted as free.
      if (free_accept) begin
        entry[tail[IDX_W-1:0]] <= free_phys;
        tail                   <= tail + 1'b1;
      end
      if (free_drop) begin
        err_overflow <= 1'b1;
      end
      if (free_is_zero) begin
        err_zero <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb/tb_phys_reg_free_list.sv - scoreboard bench for phys_reg_free_list against a queue reference model

module tb_phys_reg_free_list;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int PHYS_W   = 6;
  localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alloc_req = 1'b0;
  logic              alloc_valid;
  logic [PHYS_W-1:0] alloc_phys;
  logic              alloc_grant;
  logic              free_valid = 1'b0;
  logic [PHYS_W-1:0] free_phys = '0;
  logic              checkpoint = 1'b0;
  logic              recover = 1'b0;
  logic [CNT_W-1:0]  free_count;
  logic              err_overflow;
  logic              err_zero;

  phys_reg_free_list #(
    .NUM_ARCH(NUM_ARCH),
    .NUM_PHYS(NUM_PHYS),
    .PHYS_W  (PHYS_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_req   (alloc_req),
    .alloc_valid (alloc_valid),
    .alloc_phys  (alloc_phys),
    .alloc_grant (alloc_grant),
    .free_valid  (free_valid),
    .free_phys   (free_phys),
    .checkpoint  (checkpoint),
    .recover     (recover),
    .free_count  (free_count),
    .err_overflow(err_overflow),
    .err_zero    (err_zero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: free list as a plain queue, plus the rename-side view
  // of which registers are held (committed may be returned; spec are
  // allocations younger than the last checkpoint and may be squashed).
  int q[$];
  int spec[$];
  int committed[$];
  bit m_ovf;
  bit m_zero;
  int tail_adv;

  typedef struct {
    bit grant;
    int count;
    bit valid;
    bit ovf;
    bit zero;
  } st_t;

  st_t sq[$];
  int  gq[$];

  task automatic model_reset();
    q.delete();
    spec.delete();
    committed.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(NUM_ARCH + i);
    for (int i = 1; i < NUM_ARCH; i++) committed.push_back(i);
    m_ovf  = 1'b0;
    m_zero = 1'b0;
  endtask

  // Drive one cycle of stimulus at posedge+1, record expectations, advance.
  task automatic step(input bit req, input bit fv, input int fp, input bit ck, input bit rc);
    st_t s;
    bit  g;
    int  p;
    int  idx[$];
    alloc_req  = req;
    free_valid = fv;
    free_phys  = PHYS_W'(fp);
    checkpoint = ck;
    recover    = rc;
    g = req && (q.size() > 0) && !rc;
    s.grant = g;
    s.count = q.size();
    s.valid = (q.size() > 0);
    s.ovf   = m_ovf;
    s.zero  = m_zero;
    sq.push_back(s);
    if (g) begin
      p = q.pop_front();
      gq.push_back(p);
      spec.push_back(p);
    end
    if (fv) begin
      if (fp == 0) begin
        m_zero = 1'b1;
      end else if (s.count < DEPTH || g) begin
        q.push_back(fp);
        tail_adv++;
        idx = committed.find_first_index(x) with (x == fp);
        if (idx.size() > 0) committed.delete(idx[0]);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (rc) begin
      for (int i = spec.size() - 1; i >= 0; i--) q.push_front(spec[i]);
      spec.delete();
    end
    if (ck) begin
      foreach (spec[i]) committed.push_back(spec[i]);
      spec.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_phys  = '0;
    checkpoint = 1'b0;
    recover    = 1'b0;
    rst        = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: status every cycle, granted register whenever the DUT grants.
  always @(negedge clk) begin
    if (!rst) begin
      if (sq.size() > 0) begin
        st_t s;
        s = sq.pop_front();
        chk("grant", int'(alloc_grant), int'(s.grant));
        chk("alloc_valid", int'(alloc_valid), int'(s.valid));
        chk("free_count", int'(free_count), s.count);
        chk("err_overflow", int'(err_overflow), int'(s.ovf));
        chk("err_zero", int'(err_zero), int'(s.zero));
        chk("count_max", int'(free_count <= DEPTH), 1);
      end
      if (alloc_grant) begin
        if (gq.size() > 0) begin
          chk("alloc_phys", int'(alloc_phys), gq.pop_front());
        end else begin
          chk("unexpected_grant", 1, 0);
        end
      end
    end
  end

  initial begin
    bit req, fv, ck, rc;
    int fp;

    // Reset state
    do_reset();
    chk("rst_valid", int'(alloc_valid), 1);
    chk("rst_phys", int'(alloc_phys), NUM_ARCH);
    chk("rst_count", int'(free_count), DEPTH);
    chk("rst_ovf", int'(err_overflow), 0);
    chk("rst_zero", int'(err_zero), 0);
    alloc_req = 1'b1;
    #1;
    chk("rst_grant", int'(alloc_grant), 1);
    alloc_req = 1'b0;
    #1;
    chk("rst_nogrant", int'(alloc_grant), 0);

    // Drain: 32 grants of 32..63, then empty
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0);
    chk("empty_count", int'(free_count), 0);
    chk("empty_valid", int'(alloc_valid), 0);
    chk("empty_grant", int'(alloc_grant), 0);

    // Empty with free + alloc_req: no bypass
    step(1, 1, 5, 0, 0);
    chk("nobypass_phys", int'(alloc_phys), 5);
    chk("nobypass_count", int'(free_count), 1);
    step(1, 0, 0, 0, 0);
    chk("nobypass_after", int'(free_count), 0);

    // Checkpoint / recover
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("rec_phys", int'(alloc_phys), 35);
    chk("rec_count", int'(free_count), 29);

    // Overflow when full, and full + grant acceptance
    do_reset();
    step(0, 1, 40, 0, 0);
    chk("ovf_flag", int'(err_overflow), 1);
    chk("ovf_count", int'(free_count), DEPTH);
    do_reset();
    step(1, 1, 41, 0, 0);
    chk("fullgrant_ovf", int'(err_overflow), 0);
    chk("fullgrant_count", int'(free_count), DEPTH);

    // Zero return, then asynchronous reset mid-stream
    step(0, 1, 0, 0, 0);
    chk("zero_flag", int'(err_zero), 1);
    chk("zero_count", int'(free_count), DEPTH);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    alloc_req = 1'b0;
    rst       = 1'b1;
    #1;
    chk("arst_zero", int'(err_zero), 0);
    chk("arst_count", int'(free_count), DEPTH);
    chk("arst_phys", int'(alloc_phys), NUM_ARCH);
    @(posedge clk);
    #1;
    do_reset();

    // Randomized traffic; returns come only from committed registers, so the
    // rename-side invariant (every free list slot is either free or squashable)
    // holds as it would in the real pipeline.
    tail_adv = 0;
    for (int c = 0; c < 12000; c++) begin
      req = ($urandom_range(0, 9) < 6);
      ck  = ($urandom_range(0, 9) < 2);
      rc  = ($urandom_range(0, 19) == 0);
      fv  = (committed.size() > NUM_ARCH - 1) && ($urandom_range(0, 9) < 7);
      fp  = fv ? committed[$urandom_range(0, committed.size() - 1)] : 0;
      step(req, fv, fp, ck, rc);
    end
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    checkpoint = 1'b0;
    recover    = 1'b0;
    @(posedge clk);
    #1;
    chk("grants_drained", gq.size(), 0);
    chk("wraps_over_100", int'((tail_adv / DEPTH) > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
